fence_flush_seq: RTL and testbench

Sequencer for fence-class ops (FENCE, FENCE.I, full flush). Waits for store-buffer drain, then issues flush/invalidate requests to N cache channels with per-channel handshakes, and signals completion to commit. Successor to the fixed one-D-cache/one-I-cache fence handling: channel count, flush-on-fence and invalidate-on-flush policy, and a watchdog are all parametrised. Sits between commit/controller and the cache subsystem (HPDcache write-back, I-cache, optional extra channels).

---
 rtl/fence_flush_pkg.sv | 57 +++++
 rtl/fence_flush_seq_watchdog.sv | 37 +++
 rtl/fence_flush_seq.sv | 148 ++++++++++++++
 tb/tb_fence_flush_seq.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fence_flush_pkg.sv
// Shared types and the mode-vector decode for the fence/flush sequencer.
package fence_flush_pkg;

  localparam int unsigned MaxChannels = 8;

  typedef enum logic [1:0] {
    KindFence    = 2'd0,
    KindFenceI   = 2'd1,
    KindFlushAll = 2'd2,
    KindRsvd     = 2'd3
  } fence_kind_e;

  typedef enum logic [1:0] {
    ModeNone       = 2'd0,
    ModeFlush      = 2'd1,
    ModeInval      = 2'd2,
    ModeFlushInval = 2'd3
  } chan_mode_e;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Per-channel 2-bit modes; a channel in both masks gets the union of both actions.
  function automatic logic [2*MaxChannels-1:0] calc_modes(
    input fence_kind_e            kind,
    input logic [MaxChannels-1:0] d_mask,
    input logic [MaxChannels-1:0] i_mask,
    input logic                   flush_on_fence,
    input logic                   inval_on_flush
  );
    logic [2*MaxChannels-1:0] modes;
    logic [1:0]               d_mode;
    logic [1:0]               m;
    modes  = '0;
    d_mode = inval_on_flush ? ModeFlushInval : ModeFlush;
    for (int i = 0; i < MaxChannels; i++) begin
      m = ModeNone;
      unique case (kind)
        KindFlushAll: m = ModeFlushInval;
        KindFenceI: begin
          if (d_mask[i]) m = m | d_mode;
          if (i_mask[i]) m = m | ModeInval;
        end
        default: begin
          if (d_mask[i] && flush_on_fence) m = d_mode;
        end
      endcase
      modes[2*i +: 2] = m;
    end
    return modes;
  endfunction

endpackage

// File: rtl/fence_flush_seq_watchdog.sv
// Saturating watchdog counter for the fence sequencer.
module fence_watchdog #(
  parameter int unsigned Limit    = 16,
  parameter int unsigned CntWidth = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CntWidth-1:0] LimitC = CntWidth'(Limit);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  // The accept cycle counts as the first elapsed cycle, so done lands Limit cycles after accept.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = CntWidth'(1);
    end else if (en_i && (cnt_q != LimitC)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q >= (LimitC - 1'b1));

endmodule

// File: rtl/fence_flush_seq.sv
// Fence/flush sequencer: drains the store buffer, then handshakes flush/invalidate with N caches.
module fence_flush_seq
  import fence_flush_pkg::*;
#(
  parameter int unsigned           NrChannels        = 2,
  parameter logic [NrChannels-1:0] DChanMask         = 'b01,
  parameter logic [NrChannels-1:0] IChanMask         = 'b10,
  parameter bit                    FlushOnFence      = 1'b1,
  parameter bit                    InvalidateOnFlush = 1'b0,
  parameter int unsigned           TimeoutCycles     = 0,
  parameter int unsigned           CntWidth          =
      (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [1:0]              req_kind_i,
  input  logic                    sb_empty_i,
  output logic [NrChannels-1:0]   chan_req_o,
  output logic [2*NrChannels-1:0] chan_mode_o,
  input  logic [NrChannels-1:0]   chan_ack_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    timeout_o
);

  state_e                  state_q, state_d;
  logic [2*NrChannels-1:0] mode_q, mode_d;
  logic [NrChannels-1:0]   pending_q, pending_d;
  logic                    timeout_q, timeout_d;

  logic [MaxChannels-1:0]   d_mask_ext, i_mask_ext;
  logic [2*MaxChannels-1:0] mode_all;
  logic [2*NrChannels-1:0]  mode_sel;
  logic [NrChannels-1:0]    load_mask;
  logic                     wd_clear, wd_en, wd_expired;

  always_comb begin
    d_mask_ext                 = '0;
    i_mask_ext                 = '0;
    d_mask_ext[NrChannels-1:0] = DChanMask;
    i_mask_ext[NrChannels-1:0] = IChanMask;
    mode_all = calc_modes(fence_kind_e'(req_kind_i), d_mask_ext, i_mask_ext,
                          FlushOnFence, InvalidateOnFlush);
    mode_sel = mode_all[2*NrChannels-1:0];
    for (int i = 0; i < NrChannels; i++) begin
      load_mask[i] = |mode_q[2*i +: 2];
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    pending_d   = pending_q;
    timeout_d   = timeout_q;
    req_ready_o = 1'b0;
    wd_clear    = 1'b0;
    wd_en       = 1'b0;
    chan_req_o  = '0;
    chan_mode_o = '0;
    unique case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          mode_d    = mode_sel;
          pending_d = '0;
          timeout_d = 1'b0;
          wd_clear  = 1'b1;
          state_d   = StDrain;
        end
      end
      StDrain: begin
        wd_en = 1'b1;
        // An empty request set completes normally even if the watchdog fires this cycle.
        if (sb_empty_i && (load_mask == '0)) begin
          state_d = StDone;
        end else if (wd_expired) begin
          timeout_d = 1'b1;
          state_d   = StDone;
        end else if (sb_empty_i) begin
          pending_d = load_mask;
          state_d   = StWait;
        end
      end
      StWait: begin
        wd_en      = 1'b1;
        chan_req_o = pending_q;
        for (int i = 0; i < NrChannels; i++) begin
          chan_mode_o[2*i +: 2] = pending_q[i] ? mode_q[2*i +: 2] : 2'b00;
        end
        pending_d = pending_q & ~chan_ack_i;
        if (pending_d == '0) begin
          state_d = StDone;
        end else if (wd_expired) begin
          pending_d = '0;
          timeout_d = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        pending_d = '0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      mode_q    <= '0;
      pending_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      pending_q <= pending_d;
      timeout_q <= timeout_d;
    end
  end

  if (TimeoutCycles > 0) begin : g_wd
    fence_watchdog #(
      .Limit    (TimeoutCycles),
      .CntWidth (CntWidth)
    ) u_watchdog (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (wd_clear),
      .en_i      (wd_en),
      .expired_o (wd_expired)
    );
  end else begin : g_no_wd
    assign wd_expired = wd_en & wd_clear & 1'b0;
  end

  assign busy_o    = (state_q != StIdle);
  assign done_o    = (state_q == StDone);
  assign timeout_o = done_o & timeout_q;

  a_req_rise_only_on_drain_exit : assert property (@(posedge clk_i) disable iff (rst_i)
    ((chan_req_o & ~$past(chan_req_o)) != '0) |-> ($past(state_q) == StDrain && state_q == StWait));

  a_done_single_pulse : assert property (@(posedge clk_i) disable iff (rst_i)
    done_o |=> !done_o);

endmodule

// File: tb/tb_fence_flush_seq.sv
// Bench for fence_flush_seq: a default 2-channel instance and a 4-channel watchdog instance.
module tb_fence_flush_seq;

  logic clk;
  logic rst;
  logic       valid [2];
  logic [1:0] kind  [2];
  logic       sb    [2];
  logic [7:0] ack   [2];

  logic [1:0] a_req;
  logic [3:0] a_mode;
  logic       a_rdy, a_busy, a_done, a_to;
  logic [3:0] b_req;
  logic [7:0] b_mode;
  logic       b_rdy, b_busy, b_done, b_to;

  fence_flush_seq #(
    .NrChannels(2), .DChanMask(2'b01), .IChanMask(2'b10),
    .FlushOnFence(1'b1), .InvalidateOnFlush(1'b0), .TimeoutCycles(0)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid[0]), .req_ready_o(a_rdy),
    .req_kind_i(kind[0]), .sb_empty_i(sb[0]), .chan_req_o(a_req), .chan_mode_o(a_mode),
    .chan_ack_i(ack[0][1:0]), .busy_o(a_busy), .done_o(a_done), .timeout_o(a_to)
  );

  fence_flush_seq #(
    .NrChannels(4), .DChanMask(4'b0011), .IChanMask(4'b0100),
    .FlushOnFence(1'b0), .InvalidateOnFlush(1'b1), .TimeoutCycles(16)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid[1]), .req_ready_o(b_rdy),
    .req_kind_i(kind[1]), .sb_empty_i(sb[1]), .chan_req_o(b_req), .chan_mode_o(b_mode),
    .chan_ack_i(ack[1][3:0]), .busy_o(b_busy), .done_o(b_done), .timeout_o(b_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  int cyc;

  // Instance configuration as seen by the model
  int         pn  [2];
  logic [7:0] dm  [2];
  logic [7:0] im  [2];
  bit         fof [2];
  bit         iof [2];
  int         tmo [2];

  // Model: timestamps of accept, drain and done per operation
  bit         m_active [2];
  bit         m_tout   [2];
  int         m_tacc   [2];
  int         m_tdrain [2];
  int         m_tdone  [2];
  logic [7:0] m_pend   [2];
  logic [1:0] m_mode   [2][8];

  int acc_seen  [2];
  int done_seen [2];
  bit to_seen   [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input int d);
    logic [7:0]  ar, er;
    logic [15:0] am, em;
    logic        ab, ard, adn, ato, eb, edn, eto;
    logic [1:0]  m;
    if (d == 0) begin
      ar = {6'b0, a_req}; am = {12'b0, a_mode};
      ab = a_busy; ard = a_rdy; adn = a_done; ato = a_to;
    end else begin
      ar = {4'b0, b_req}; am = {8'b0, b_mode};
      ab = b_busy; ard = b_rdy; adn = b_done; ato = b_to;
    end
    if (rst) m_active[d] = 1'b0;
    eb  = m_active[d];
    edn = m_active[d] && (m_tdone[d] == cyc);
    eto = edn && m_tout[d];
    er  = '0;
    em  = '0;
    if (m_active[d] && (m_tdrain[d] >= 0) && (cyc > m_tdrain[d]) && !edn) begin
      er = m_pend[d];
      for (int ch = 0; ch < 8; ch++) begin
        if (er[ch]) em[2*ch +: 2] = m_mode[d][ch];
      end
    end
    check(d == 0 ? "a_req" : "b_req", {24'b0, ar}, {24'b0, er});
    check(d == 0 ? "a_mode" : "b_mode", {16'b0, am}, {16'b0, em});
    check(d == 0 ? "a_busy" : "b_busy", {31'b0, ab}, {31'b0, eb});
    check(d == 0 ? "a_ready" : "b_ready", {31'b0, ard}, {31'b0, !eb});
    check(d == 0 ? "a_done" : "b_done", {31'b0, adn}, {31'b0, edn});
    check(d == 0 ? "a_timeout" : "b_timeout", {31'b0, ato}, {31'b0, eto});
    if (adn) begin
      done_seen[d] = cyc;
      to_seen[d]   = ato;
    end
    if (!rst) begin
      if (!m_active[d]) begin
        if (valid[d]) begin
          m_active[d] = 1'b1;
          m_tout[d]   = 1'b0;
          m_tacc[d]   = cyc;
          m_tdrain[d] = -1;
          m_tdone[d]  = -1;
          m_pend[d]   = '0;
          acc_seen[d] = cyc;
          for (int ch = 0; ch < 8; ch++) begin
            m = 2'd0;
            if (ch < pn[d]) begin
              if (kind[d] == 2'd2) begin
                m = 2'd3;
              end else if (kind[d] == 2'd1) begin
                if (dm[d][ch]) m = m | (iof[d] ? 2'd3 : 2'd1);
                if (im[d][ch]) m = m | 2'd2;
              end else if (dm[d][ch] && fof[d]) begin
                m = iof[d] ? 2'd3 : 2'd1;
              end
            end
            m_mode[d][ch] = m;
          end
        end
      end else if (m_tdone[d] == cyc) begin
        m_active[d] = 1'b0;
      end else begin
        if (m_tdrain[d] < 0) begin
          if (sb[d]) begin
            m_tdrain[d] = cyc;
            for (int ch = 0; ch < 8; ch++) m_pend[d][ch] = (m_mode[d][ch] != 2'd0);
            if (m_pend[d] == '0) m_tdone[d] = cyc + 1;
          end
        end else begin
          m_pend[d] = m_pend[d] & ~ack[d];
          if (m_pend[d] == '0) m_tdone[d] = cyc + 1;
        end
        // Watchdog deadline: done lands exactly tmo cycles after accept
        if ((m_tdone[d] < 0) && (tmo[d] > 0) && (cyc + 1 == m_tacc[d] + tmo[d])) begin
          m_tdone[d] = cyc + 1;
          m_tout[d]  = 1'b1;
          m_pend[d]  = '0;
        end
      end
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) model_step(d);
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  int first_acc;

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    pn[0] = 2; dm[0] = 8'h01; im[0] = 8'h02; fof[0] = 1'b1; iof[0] = 1'b0; tmo[0] = 0;
    pn[1] = 4; dm[1] = 8'h03; im[1] = 8'h04; fof[1] = 1'b0; iof[1] = 1'b1; tmo[1] = 16;
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0; m_tout[d] = 1'b0; m_tacc[d] = 0; m_tdrain[d] = -1;
      m_tdone[d] = -1; m_pend[d] = '0; acc_seen[d] = -1; done_seen[d] = -1; to_seen[d] = 1'b0;
      valid[d] = 1'b0; kind[d] = 2'd0; sb[d] = 1'b1; ack[d] = '0;
    end
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    #1;
    check("reset_ready_a", {31'b0, a_rdy}, 32'd1);
    check("reset_req_b", {28'b0, b_req}, 32'd0);
    tick(2);

    // FENCE on defaults, ch0 acks one cycle after the request appears
    valid[0] = 1'b1; kind[0] = 2'd0;
    tick(1);
    valid[0] = 1'b0;
    tick(1);
    check("t1_req", {30'b0, a_req}, 32'h1);
    check("t1_mode", {28'b0, a_mode}, 32'h1);
    tick(1);
    ack[0] = 8'h01;
    tick(1);
    ack[0] = 8'h00;
    tick(3);
    check("t1_latency", done_seen[0] - acc_seen[0], 32'd4);
    check("t1_timeout", {31'b0, to_seen[0]}, 32'd0);

    // FENCE_I with a 5-cycle drain, acks staggered plus a duplicate ack
    sb[0] = 1'b0; valid[0] = 1'b1; kind[0] = 2'd1;
    tick(1);
    valid[0] = 1'b0;
    tick(5);
    check("t2_req_drain", {30'b0, a_req}, 32'h0);
    sb[0] = 1'b1;
    tick(1);
    check("t2_req", {30'b0, a_req}, 32'h3);
    check("t2_mode", {28'b0, a_mode}, 32'h9);
    ack[0] = 8'h02;
    tick(1);
    tick(1);
    ack[0] = 8'h01;
    tick(1);
    ack[0] = 8'h00;
    tick(3);
    check("t2_latency", done_seen[0] - acc_seen[0], 32'd10);

    // FLUSH_ALL on 4 channels, all acks in the first request cycle
    valid[1] = 1'b1; kind[1] = 2'd2;
    tick(1);
    valid[1] = 1'b0;
    tick(1);
    check("t3_req", {28'b0, b_req}, 32'hF);
    check("t3_mode", {24'b0, b_mode}, 32'hFF);
    ack[1] = 8'h0F;
    tick(1);
    ack[1] = 8'h00;
    check("t3_done_now", {31'b0, b_done}, 32'd1);
    tick(2);
    check("t3_latency", done_seen[1] - acc_seen[1], 32'd3);

    // FENCE with FlushOnFence=0 and valid held: back-to-back accepts
    valid[1] = 1'b1; kind[1] = 2'd0;
    tick(1);
    first_acc = acc_seen[1];
    tick(3);
    check("t4_latency", done_seen[1] - first_acc, 32'd2);
    check("t4_reaccept", acc_seen[1] - first_acc, 32'd3);
    valid[1] = 1'b0;
    tick(3);

    // FENCE_I where ch1 never acks; watchdog must fire
    valid[1] = 1'b1; kind[1] = 2'd1;
    tick(1);
    valid[1] = 1'b0;
    tick(1);
    check("t5_mode", {24'b0, b_mode}, 32'h2F);
    ack[1] = 8'h05;
    tick(1);
    ack[1] = 8'h01;
    tick(1);
    ack[1] = 8'h00;
    tick(13);
    check("t5_latency", done_seen[1] - acc_seen[1], 32'd16);
    check("t5_timeout", {31'b0, to_seen[1]}, 32'd1);
    tick(2);

    // Reset while waiting on acks, then a clean FENCE
    valid[0] = 1'b1; kind[0] = 2'd0;
    tick(1);
    valid[0] = 1'b0;
    tick(1);
    rst = 1'b1;
    #1;
    check("t6_req_reset", {30'b0, a_req}, 32'h0);
    check("t6_busy_reset", {31'b0, a_busy}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    valid[0] = 1'b1; kind[0] = 2'd3;
    tick(1);
    valid[0] = 1'b0;
    tick(1);
    ack[0] = 8'h01;
    tick(1);
    ack[0] = 8'h00;
    tick(3);
    check("t6_latency", done_seen[0] - acc_seen[0], 32'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
